// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          DEF_PHASE_CYCLES = 2;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'd1024;
    localparam int          SRAM_AW          = 18;

    // Byte address to 32-bit SRAM word index, relative to the mapped base.
    // The word index is one bit narrower than the half-word SRAM address.
    function automatic logic [SRAM_AW-2:0] word_of(input logic [31:0] addr,
                                                   input logic [31:0] base);
        return (SRAM_AW-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request side and SRAM side of the memory-stage controller.
// slave is the controller's view, master is the surrounding system's view.
interface mem_access_ctrl_if;
    import mem_ctrl_pkg::*;

    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        address;
    logic [31:0]        ST_val;
    logic               ready;
    logic [31:0]        read_data;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_out;
    logic [15:0]        SRAM_DQ_in;
    logic               SRAM_DQ_oe;
    logic               SRAM_WE_N;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, ST_val, SRAM_DQ_in,
        output ready, read_data, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, address, ST_val, SRAM_DQ_in,
        input  ready, read_data, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

endinterface

// File: rtl/mem_access_ctrl_phase_counter.sv
// Cycle counter for one half-word phase; tc flags the last cycle of a phase.
module phase_counter #(
    parameter  int PHASE_CYCLES = 2,
    localparam int CW           = $clog2(PHASE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(PHASE_CYCLES - 1));

    // Clear has priority so the count restarts at 0 on every phase boundary.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns one 32-bit load/store into two half-word
// SRAM phases and stalls the pipeline (ready low) until the access is done.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          PHASE_CYCLES = DEF_PHASE_CYCLES,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);

    state_t             state;
    logic               is_write;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        st_val;
    logic [15:0]        lo_data;
    logic [31:0]        read_data;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        dq_out;
    logic               dq_oe;
    logic               we_n;

    logic req;
    logic in_phase;
    logic tc;

    assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
    assign in_phase = (state == LOW) || (state == HIGH);

    // Counter only runs inside a phase and is cleared on its last cycle.
    phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_counter (
        .clk (clk),
        .rst (rst),
        .clr (!in_phase || tc),
        .en  (in_phase),
        .tc  (tc)
    );

    // Sequencer; SRAM outputs are registered from the state being entered,
    // so they never follow the request inputs combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            word      <= '0;
            st_val    <= '0;
            lo_data   <= '0;
            read_data <= '0;
            sram_addr <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            we_n      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are set.
                        state     <= LOW;
                        is_write  <= bus.MEM_W_EN;
                        word      <= word_of(bus.address, BASE_ADDR);
                        st_val    <= bus.ST_val;
                        sram_addr <= {word_of(bus.address, BASE_ADDR), 1'b0};
                        dq_oe     <= bus.MEM_W_EN;
                        we_n      <= !bus.MEM_W_EN;
                        dq_out    <= bus.MEM_W_EN ? bus.ST_val[15:0] : 16'h0;
                    end
                end
                LOW: begin
                    if (tc) begin
                        state     <= HIGH;
                        sram_addr <= {word, 1'b1};
                        dq_out    <= is_write ? st_val[31:16] : 16'h0;
                        if (!is_write)
                            lo_data <= bus.SRAM_DQ_in;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        state     <= DONE;
                        sram_addr <= '0;
                        dq_out    <= '0;
                        dq_oe     <= 1'b0;
                        we_n      <= 1'b1;
                        if (!is_write)
                            read_data <= {bus.SRAM_DQ_in, lo_data};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready       = ((state == IDLE) && !req) || (state == DONE);
    assign bus.read_data   = read_data;
    assign bus.SRAM_ADDR   = sram_addr;
    assign bus.SRAM_DQ_out = dq_out;
    assign bus.SRAM_DQ_oe  = dq_oe;
    assign bus.SRAM_WE_N   = we_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle vector table for the default
// phase length, plus hand-written idle, reset and short-phase sequences.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus0();
    mem_access_ctrl_if bus1();

    mem_access_ctrl dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_access_ctrl #(.PHASE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Small SRAM model behind dut0, with a few words preloaded during reset.
    logic [15:0] mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 16'h1111;
            mem[1] <= 16'h2222;
            mem[4] <= 16'h3333;
            mem[5] <= 16'h4444;
        end else if (!bus0.SRAM_WE_N) begin
            mem[bus0.SRAM_ADDR[5:0]] <= bus0.SRAM_DQ_out;
        end
    end
    assign bus0.SRAM_DQ_in = mem[bus0.SRAM_ADDR[5:0]];

    // Fixed pattern behind dut1: even half-word A5A5, odd half-word C3C3.
    assign bus1.SRAM_DQ_in = bus1.SRAM_ADDR[0] ? 16'hC3C3 : 16'hA5A5;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] st;
        logic        rdy;
        logic [17:0] sa;
        logic        we_n;
        logic        oe;
        logic [15:0] dq;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] st, input logic rdy, input logic [17:0] sa,
                       input logic we_n, input logic oe, input logic [15:0] dq,
                       input logic [31:0] rd);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.st = st;
        v.rdy = rdy; v.sa = sa; v.we_n = we_n; v.oe = oe; v.dq = dq; v.rd = rd;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int low;
        int n;
        bit done;

        bus0.MEM_R_EN = 0; bus0.MEM_W_EN = 0; bus0.address = 0; bus0.ST_val = 0;
        bus1.MEM_R_EN = 0; bus1.MEM_W_EN = 0; bus1.address = 0; bus1.ST_val = 0;

        //   n  r  w  address      ST_val        rdy addr we oe dq        read_data
        add(1, 0, 0, 32'd0,    32'h0,        1, 0, 1, 0, 16'h0,    32'h0);        // reset state
        add(1, 0, 1, 32'd1028, 32'hDEADBEEF, 0, 0, 1, 0, 16'h0,    32'h0);        // write seen in IDLE
        add(2, 0, 1, 32'd1028, 32'hDEADBEEF, 0, 2, 0, 1, 16'hBEEF, 32'h0);        // LOW
        add(2, 0, 1, 32'd1028, 32'hDEADBEEF, 0, 3, 0, 1, 16'hDEAD, 32'h0);        // HIGH
        add(1, 0, 1, 32'd1028, 32'hDEADBEEF, 1, 0, 1, 0, 16'h0,    32'h0);        // DONE
        add(1, 1, 0, 32'd1028, 32'h0,        0, 0, 1, 0, 16'h0,    32'h0);        // read back
        add(2, 1, 0, 32'd1028, 32'h0,        0, 2, 1, 0, 16'h0,    32'h0);
        add(2, 1, 0, 32'd1028, 32'h0,        0, 3, 1, 0, 16'h0,    32'h0);
        add(1, 1, 0, 32'd1028, 32'h0,        1, 0, 1, 0, 16'h0,    32'hDEADBEEF);
        add(1, 0, 0, 32'd0,    32'h0,        1, 0, 1, 0, 16'h0,    32'hDEADBEEF);
        add(1, 1, 0, 32'd1024, 32'h0,        0, 0, 1, 0, 16'h0,    32'hDEADBEEF); // back-to-back #1
        add(2, 1, 0, 32'd1024, 32'h0,        0, 0, 1, 0, 16'h0,    32'hDEADBEEF);
        add(2, 1, 0, 32'd1024, 32'h0,        0, 1, 1, 0, 16'h0,    32'hDEADBEEF);
        add(1, 1, 0, 32'd1024, 32'h0,        1, 0, 1, 0, 16'h0,    32'h22221111);
        add(1, 1, 0, 32'd1032, 32'h0,        0, 0, 1, 0, 16'h0,    32'h22221111); // back-to-back #2
        add(2, 1, 0, 32'd1032, 32'h0,        0, 4, 1, 0, 16'h0,    32'h22221111);
        add(2, 1, 0, 32'd1032, 32'h0,        0, 5, 1, 0, 16'h0,    32'h22221111);
        add(1, 1, 0, 32'd1032, 32'h0,        1, 0, 1, 0, 16'h0,    32'h44443333);
        add(1, 1, 1, 32'd1040, 32'h12345678, 0, 0, 1, 0, 16'h0,    32'h44443333); // both enables
        add(2, 1, 1, 32'd1040, 32'h12345678, 0, 8, 0, 1, 16'h5678, 32'h44443333);
        add(2, 1, 1, 32'd1040, 32'h12345678, 0, 9, 0, 1, 16'h1234, 32'h44443333);
        add(1, 1, 1, 32'd1040, 32'h12345678, 1, 0, 1, 0, 16'h0,    32'h44443333);
        add(1, 0, 0, 32'd0,    32'h0,        1, 0, 1, 0, 16'h0,    32'h44443333);

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = 0;
            bus0.MEM_R_EN = tbl[i].r;
            bus0.MEM_W_EN = tbl[i].w;
            bus0.address  = tbl[i].a;
            bus0.ST_val   = tbl[i].st;
            #1;
            chk($sformatf("row%0d ready", i),     32'(bus0.ready),       32'(tbl[i].rdy));
            chk($sformatf("row%0d sram_addr", i), 32'(bus0.SRAM_ADDR),   32'(tbl[i].sa));
            chk($sformatf("row%0d we_n", i),      32'(bus0.SRAM_WE_N),   32'(tbl[i].we_n));
            chk($sformatf("row%0d dq_oe", i),     32'(bus0.SRAM_DQ_oe),  32'(tbl[i].oe));
            chk($sformatf("row%0d dq_out", i),    32'(bus0.SRAM_DQ_out), 32'(tbl[i].dq));
            chk($sformatf("row%0d read_data", i), bus0.read_data,        tbl[i].rd);
        end

        // Ten idle cycles: nothing requested, bus quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus0.MEM_R_EN = 0; bus0.MEM_W_EN = 0;
            #1;
            chk($sformatf("idle%0d ready", i), 32'(bus0.ready),      32'd1);
            chk($sformatf("idle%0d we_n", i),  32'(bus0.SRAM_WE_N),  32'd1);
            chk($sformatf("idle%0d dq_oe", i), 32'(bus0.SRAM_DQ_oe), 32'd0);
        end

        // Reset during the HIGH phase of a read.
        @(negedge clk); bus0.MEM_R_EN = 1; bus0.address = 32'd1024;  // IDLE
        @(negedge clk);                                               // LOW
        @(negedge clk);                                               // LOW
        @(negedge clk); #1;                                           // HIGH
        chk("rst_mid in_high addr", 32'(bus0.SRAM_ADDR), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mid read_data", bus0.read_data,          32'h0);
        chk("rst_mid we_n",      32'(bus0.SRAM_WE_N),     32'd1);
        chk("rst_mid addr",      32'(bus0.SRAM_ADDR),     32'd0);
        chk("rst_mid ready_req", 32'(bus0.ready),         32'd0);
        bus0.MEM_R_EN = 0;
        #1;
        chk("rst_mid ready_noreq", 32'(bus0.ready), 32'd1);

        // Single-cycle phases: ready low 3 cycles, 4 cycles in total.
        @(negedge clk);
        bus1.MEM_R_EN = 1; bus1.address = 32'd1024;
        low = 0; n = 0; done = 0;
        while (n < 20 && !done) begin
            #1;
            n++;
            if (bus1.ready) done = 1;
            else begin
                low++;
                @(negedge clk);
            end
        end
        chk("p1 completed",  32'(done), 32'd1);
        chk("p1 ready_low",  32'(low),  32'd3);
        chk("p1 total",      32'(n),    32'd4);
        chk("p1 read_data",  bus1.read_data, 32'hC3C3A5A5);
        @(negedge clk);
        bus1.MEM_R_EN = 0;
        #1;
        chk("p1 idle ready", 32'(bus1.ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the memory stage of the pipeline. It takes the memory-read and memory-write enables, ALU-computed address and store value that the EXE/MEM pipeline register presents, and runs a multi-cycle access on a 16-bit external SRAM as two half-word phases. While an access is in flight it holds `ready` low. The top level drives the `ld` input of every pipeline register from `ready`, which freezes the pipeline until the memory stage completes.

## Interface
Parameters:
- `PHASE_CYCLES`, default 2: cycles per half-word phase (≥1).
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `MEM_R_EN` in 1: read request from EXE/MEM register.
- `MEM_W_EN` in 1: write request from EXE/MEM register.
- `address` in 32: byte address (`alu_result`).
- `ST_val` in 32: store data.
- `ready` out 1: 1 when no access is pending or the access completes this cycle; drives pipeline `ld`.
- `read_data` out 32: loaded word, held until the next read completes.
- `SRAM_ADDR` out 18: half-word address.
- `SRAM_DQ_out` out 16: write data.
- `SRAM_DQ_in` in 16: read data.
- `SRAM_DQ_oe` out 1: data-bus drive enable.
- `SRAM_WE_N` out 1: active-low write strobe.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. Phase counter runs 0..PHASE_CYCLES-1.
- **IDLE:**
  - When `MEM_R_EN` or `MEM_W_EN` is 1, latch `address`, `ST_val` and the operation, then go to LOW with counter 0.
  - If both enables are 1, the access is a write.
- **Address map:** word = (address − BASE_ADDR) >> 2. The result is truncated to 17 bits. `SRAM_ADDR` = {word, 0} in LOW and {word, 1} in HIGH.
- **LOW/HIGH:**
  - Stay in the state until the counter reaches PHASE_CYCLES-1, then advance LOW→HIGH→DONE with the counter cleared.
  - Read: on the last cycle of LOW, sample `SRAM_DQ_in` into data[15:0]. On the last cycle of HIGH, sample it into data[31:16].
  - Write: `SRAM_DQ_oe`=1 and `SRAM_WE_N`=0 for every cycle of both phases. `SRAM_DQ_out` = ST_val[15:0] in LOW and ST_val[31:16] in HIGH.
- **DONE:**
  - Lasts 1 cycle with `ready`=1. On a read, `read_data` already holds the assembled word.
  - Always returns to IDLE. The next request is accepted in IDLE on the following cycle.
- **Request inputs:** ignored outside IDLE. A request that drops mid-access does not abort the access.
- **`ready`:** combinational, = (state==IDLE && !MEM_R_EN && !MEM_W_EN) || state==DONE.
- **SRAM outputs:** decoded from state, counter and latched values only. There is no combinational path from the request inputs.
- **Idle drive:** outside write phases, `SRAM_WE_N`=1, `SRAM_DQ_oe`=0 and `SRAM_DQ_out`=0.
- **`SRAM_ADDR`:** 0 in IDLE and in DONE.
- **`read_data`:** changes only at the HIGH-phase sample of a read. Writes never alter it.

## Timing
- **Reset values:** state IDLE, counter 0, `read_data`=0, `SRAM_ADDR`=0, `SRAM_DQ_out`=0, `SRAM_DQ_oe`=0, `SRAM_WE_N`=1. `ready`=1 when no request is present.
- **Access latency:**
  - Request first seen in IDLE at cycle 0, with `ready`=0.
  - LOW runs cycles 1..P and HIGH runs cycles P+1..2P, where P = PHASE_CYCLES.
  - DONE is cycle 2P+1, with `ready`=1. With the default P=2, `ready` is low for 5 cycles and the access takes 6 cycles in total.
- **Back-to-back accesses:** a new memory instruction reaches the stage the cycle after DONE and starts in IDLE. There is no idle gap beyond that cycle.
- **Reset mid-access:** on the next edge, return to IDLE with reset output values. Partial read data is discarded and `read_data` is cleared to 0.

## Structure
- **Package `mem_ctrl_pkg`:** state enum (IDLE, LOW, HIGH, DONE), default `PHASE_CYCLES`, default `BASE_ADDR`, and the SRAM address width constant (18).
- **Sub-module `phase_counter`:** synchronous counter with clear and terminal-count output (count == PHASE_CYCLES-1), width $clog2(PHASE_CYCLES)+1.
- **Top level:** external SRAM tristate (`SRAM_DQ_out`, `SRAM_DQ_in`, `SRAM_DQ_oe` combined onto the inout pin) is built outside this block.

## Test plan
- **Write then read back:** write 0xDEADBEEF to address 1028. Expect `SRAM_ADDR` 2 with DQ 0xBEEF, then 3 with 0xDEAD, `SRAM_WE_N` low for 4 cycles, and `ready` low for 5 cycles. The following read of 1028 from an SRAM model returns `read_data`=0xDEADBEEF at DONE.
- **Idle:** no request for 10 cycles → `ready`=1 throughout, `SRAM_WE_N`=1, `SRAM_DQ_oe`=0.
- **Back-to-back:** reads at 1024 and 1032 → two 6-cycle windows, each with `ready` high only in DONE. `SRAM_ADDR` sequences 0,0,1,1 then 4,4,5,5.
- **Simultaneous enables:** `MEM_R_EN`=`MEM_W_EN`=1 with ST_val 0x12345678 → a write is performed and `read_data` is unchanged.
- **Reset mid-access:** `rst` asserted in the HIGH phase of a read → the next cycle is IDLE, `read_data`=0, `SRAM_WE_N`=1, and `ready`=1 once the request is removed.
- **Phase length:** `PHASE_CYCLES`=1 → `ready` is low for 3 cycles and the access takes 4 cycles in total.
